// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller: handshake state
// encoding, vector width, default passive vector and an index-width helper.
package vic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } vic_state_t;

  localparam int VEC_W = 16;

  localparam logic [VEC_W-1:0] VEC_NONE_DEF = 16'o000000;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest
// set index, so channel 0 always wins over higher-numbered channels.
module vic_prio_enc
  import vic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  output logic                      valid,
  output logic [idx_width(N)-1:0]   idx
);

  localparam int IW = idx_width(N);

  // Scan from the top down so the last hit (lowest index) is the one kept.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vic_wbi.sv
// Vectored interrupt controller, responder side of the CPU vector handshake.
// Gathers enabled level requests into virq, and on the CPU strobe latches the
// winning channel's vector, pulses that channel's acknowledge and completes
// the iack handshake before re-arming.
module vic_wbi
  import vic_pkg::*;
#(
  parameter int               N        = 4,
  parameter logic [VEC_W-1:0] VEC_NONE = VEC_NONE_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [N-1:0]         irq_i,
  input  logic [N-1:0]         irq_en_i,
  input  logic [VEC_W*N-1:0]   ch_vec_i,
  output logic [N-1:0]         irq_ack_o,
  output logic                 virq_o,
  input  logic                 istb_i,
  output logic [VEC_W-1:0]     ivec_o,
  output logic                 iack_o
);

  localparam int IW = idx_width(N);

  vic_state_t         state, state_n;
  logic [N-1:0]       pend;
  logic               enc_valid;
  logic [IW-1:0]      enc_idx;
  logic [IW-1:0]      winner, winner_n;
  logic [VEC_W-1:0]   sel_vec;
  logic [N-1:0]       sel_onehot;
  logic               virq_n;
  logic               iack_n;
  logic [N-1:0]       irq_ack_n;
  logic [VEC_W-1:0]   ivec_n;

  assign pend = irq_i & irq_en_i;

  vic_prio_enc #(
    .N (N)
  ) u_prio_enc (
    .req   (pend),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Vector mux and one-hot acknowledge for the channel the encoder picked.
  always_comb begin
    sel_vec    = '0;
    sel_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (enc_idx == IW'(k)) begin
        sel_vec       = ch_vec_i[VEC_W*k +: VEC_W];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n   = state;
    winner_n  = winner;
    ivec_n    = ivec_o;
    iack_n    = iack_o;
    virq_n    = 1'b0;
    irq_ack_n = '0;
    unique case (state)
      IDLE: begin
        virq_n = |pend;
        if (istb_i) begin
          virq_n  = 1'b0;
          state_n = ACK;
          if (enc_valid) begin
            winner_n  = enc_idx;
            ivec_n    = sel_vec;
            irq_ack_n = sel_onehot;
          end else begin
            ivec_n = VEC_NONE;
          end
        end
      end
      ACK: begin
        iack_n  = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        iack_n = 1'b1;
        if (!istb_i) begin
          iack_n  = 1'b0;
          state_n = RECOVER;
        end
      end
      RECOVER: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the handshake immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      winner    <= '0;
      virq_o    <= 1'b0;
      iack_o    <= 1'b0;
      irq_ack_o <= '0;
      ivec_o    <= '0;
    end else begin
      state     <= state_n;
      winner    <= winner_n;
      virq_o    <= virq_n;
      iack_o    <= iack_n;
      irq_ack_o <= irq_ack_n;
      ivec_o    <= ivec_n;
    end
  end

endmodule

// File: doc/vic_wbi.md
Name: vic_wbi

Overview:
- Vectored interrupt controller; the responder end of the CPU interrupt-vector handshake (virq, istb, ivec, iack).
- Collects level requests from N peripheral channels and asserts a single virq toward the CPU module.
- On the CPU's vector strobe, selects the highest-priority pending channel, presents its vector, and acknowledges both the CPU and the winning device.
- Sits on the board top level, between the peripherals and the CPU module's ivec/istb/iack pins.

Parameters:
- N, 4, number of interrupt channels; index 0 has highest priority; legal range 1..16.
- VEC_NONE, 16'o000000, passive vector returned when no channel is pending at strobe time.

Ports:
- wb_clk_i  in  1  system clock; all logic is rising-edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- irq_i  in  N  per-channel level requests, synchronous to wb_clk_i.
- irq_en_i  in  N  per-channel enable mask; 1 means the channel is enabled.
- ch_vec_i  in  16*N  channel vectors; channel k occupies bits [16k+15:16k]; sampled only at selection.
- irq_ack_o  out  N  one-cycle acknowledge pulse to the winning channel.
- virq_o  out  1  interrupt request to the CPU.
- istb_i  in  1  vector strobe from the CPU.
- ivec_o  out  16  vector returned to the CPU.
- iack_o  out  1  vector acknowledge to the CPU.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; virq_o=0, iack_o=0, irq_ack_o=0, ivec_o=0, winner register=0.
- pend = irq_i & irq_en_i. All outputs are registered.
- IDLE:
  - virq_o <= |pend.
  - On an edge with istb_i=1: winner <= lowest set index of pend; ivec_o <= ch_vec_i[winner].
  - Same edge: irq_ack_o[winner] <= 1 for exactly one cycle; virq_o <= 0; go to ACK.
  - If pend=0 at that edge: ivec_o <= VEC_NONE, irq_ack_o stays 0, go to ACK.
- ACK:
  - iack_o <= 1 on the first edge in ACK; ivec_o is therefore stable one cycle before iack_o rises.
  - irq_ack_o returns to 0; virq_o held 0; go to HOLD.
- HOLD:
  - iack_o held 1; ivec_o held.
  - When istb_i=0 is sampled: iack_o <= 0; go to RECOVER.
  - istb_i held high indefinitely keeps the controller in HOLD; there is no timeout.
- RECOVER:
  - One cycle with virq_o=0, giving the device time to drop its request after irq_ack_o; then go to IDLE.
  - virq_o is re-evaluated on the next IDLE edge.
- Latency: istb_i high sampled at edge k gives ivec_o valid after edge k, iack_o high after edge k+1; iack_o falls one edge after istb_i=0 is sampled.
- ivec_o retains its last value outside a transaction; it is not cleared after service.
- Simultaneous requests: a fixed priority encoder picks the lowest index; there is no rotation.
- Request withdrawn after virq_o but before istb_i: that channel is not selected. If nothing remains pending, VEC_NONE is returned.
- Mask changes take effect on the next IDLE evaluation. A channel masked during ACK/HOLD does not abort the transaction.
- istb_i rising outside IDLE is ignored. Only the falling edge in HOLD is significant.
- Reset asserted mid-transaction forces all outputs low immediately; there is no completion of the handshake.

Decomposition:
- Shared package vic_pkg:
  - state encoding IDLE=2'd0, ACK=2'd1, HOLD=2'd2, RECOVER=2'd3;
  - VEC_W=16;
  - default VEC_NONE.
- One sub-module, vic_prio_enc: combinational N-bit lowest-index priority encoder.
  - Outputs: valid, plus an index of clog2(N) bits (minimum 1 bit).
- FSM, vector mux and registers live in vic_wbi.

Test Plan:
- Reset: assert wb_rst_i mid-HOLD -> virq_o, iack_o, irq_ack_o, ivec_o all 0 immediately; state IDLE after release.
- Single request:
  - Stimulus: N=4, irq_i=4'b0100, en=4'hF, ch_vec_i[2]=16'o000060; istb_i high at edge k.
  - Required: virq_o=1 before the strobe; ivec_o=16'o000060 after edge k; irq_ack_o=4'b0100 for one cycle; iack_o=1 after edge k+1.
  - Then: istb_i low -> iack_o=0 next edge, virq_o low for the RECOVER cycle.
- Priority: irq_i=4'b1010, vectors ch1=16'o000064, ch3=16'o000100 -> first service returns 16'o000064 with irq_ack_o[1]; after ch1 drops, second service returns 16'o000100.
- Mask: irq_i=4'b0001, irq_en_i=4'b1110 -> virq_o stays 0; a forced istb_i returns VEC_NONE, irq_ack_o stays 0, iack_o still completes.
- Withdrawal: virq_o=1 from ch0, irq_i cleared one cycle before istb_i -> ivec_o=VEC_NONE, no irq_ack_o pulse.
- Long strobe: istb_i held high 20 cycles -> iack_o stays 1 and ivec_o stable throughout; a second istb_i pulse during RECOVER is ignored.
